// File: rtl/hazard_sb.sv
// Hazard scoreboard: tracks in-flight producers in E..W, picks forwarding sources, raises D-stage stall.
// Latency: stall/rs_sel/rt_sel are combinational from registered state plus D inputs; state updates next edge.
// Backpressure: stall freezes F/D and inserts a bubble into E; optional MDU busy tracking under HAZARD_SB_MDU_EN.
module hazard_sb #(
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int TW       = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         d_valid,
  input  logic [AW-1:0]                d_rs,
  input  logic [AW-1:0]                d_rt,
  input  logic [TW-1:0]                d_tuse_rs,
  input  logic [TW-1:0]                d_tuse_rt,
  input  logic                         d_wr_en,
  input  logic [AW-1:0]                d_wr_addr,
  input  logic [TW-1:0]                d_tnew,
  input  logic                         d_md,
  input  logic                         md_start,
  input  logic                         md_div,
  input  logic                         flush,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]   rt_sel,
  output logic                         md_busy
);

  localparam int SW = $clog2(DEPTH + 1);

  // One tracked producer; index 1 is E, DEPTH is the oldest tracked stage.
  typedef struct packed {
    logic          vld;
    logic          wr;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t        ent [1:DEPTH];

  logic          rs_hit;
  logic          rt_hit;
  logic [TW-1:0] rs_tnew;
  logic [TW-1:0] rt_tnew;
  logic          haz_rs;
  logic          haz_rt;
  logic          md_haz;
  logic          issue;

  // tnew counts down as a producer ages and never wraps below zero.
  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - TW'(1);
  endfunction

  // Youngest-match search: walk oldest to youngest so the youngest hit wins.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_sel  = '0;
    rt_sel  = '0;
    rs_tnew = '0;
    rt_tnew = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ent[k].vld && ent[k].wr && (ent[k].addr == d_rs) && (d_rs != '0)) begin
        rs_hit  = 1'b1;
        rs_sel  = SW'(k);
        rs_tnew = ent[k].tnew;
      end
      if (ent[k].vld && ent[k].wr && (ent[k].addr == d_rt) && (d_rt != '0)) begin
        rt_hit  = 1'b1;
        rt_sel  = SW'(k);
        rt_tnew = ent[k].tnew;
      end
    end
  end

  // A source must wait while its youngest producer needs more cycles than the consumer can spare.
  // An unused source carries tuse all-ones, which no tnew can exceed.
  assign haz_rs = rs_hit & (rs_tnew > d_tuse_rs);
  assign haz_rt = rt_hit & (rt_tnew > d_tuse_rt);
  assign stall  = d_valid & (haz_rs | haz_rt | md_haz);

  // Flush kills the D instruction as well, so nothing enters E on a flush cycle.
  assign issue  = d_valid & ~stall & ~flush;

  // Pipeline shadow: load E on issue (bubble otherwise), age every older entry by one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        ent[k] <= '0;
      end
    end else begin
      if (issue) begin
        ent[1] <= '{vld: 1'b1, wr: d_wr_en, addr: d_wr_addr, tnew: d_tnew};
      end else begin
        ent[1] <= '0;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        ent[k].vld  <= ent[k-1].vld & ~flush;
        ent[k].wr   <= ent[k-1].wr;
        ent[k].addr <= ent[k-1].addr;
        ent[k].tnew <= tnew_dec(ent[k-1].tnew);
      end
    end
  end

`ifdef HAZARD_SB_MDU_EN
  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW     = $clog2(MD_MAX + 1);

  logic [CW-1:0] md_cnt;

  // MDU busy countdown: a new start always reloads, flush leaves it running.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start) begin
      md_cnt <= md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy = (md_cnt != '0);
  // The start cycle itself blocks HI/LO users, before the counter is loaded.
  assign md_haz  = d_md & (md_busy | md_start);
`else
  logic unused_md;

  assign md_busy   = 1'b0;
  assign md_haz    = 1'b0;
  assign unused_md = ^{d_md, md_start, md_div};
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: table of per-cycle vectors plus hand-built MDU and reset sequences.
// Latency: expectations describe combinational outputs within the driven cycle.
// Backpressure: none; the bench drives every cycle and checks at the falling edge.
module tb_hazard_sb;

`ifdef HAZARD_SB_MDU_EN
  localparam int MDU = 1;
`else
  localparam int MDU = 0;
`endif
  localparam int U = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [2:0] d_tuse_rs;
  logic [2:0] d_tuse_rt;
  logic       d_wr_en;
  logic [4:0] d_wr_addr;
  logic [2:0] d_tnew;
  logic       d_md;
  logic       md_start;
  logic       md_div;
  logic       flush;
  logic       stall;
  logic [1:0] rs_sel;
  logic [1:0] rt_sel;
  logic       md_busy;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_sb #(
    .DEPTH(3), .AW(5), .TW(3), .MULT_CYC(5), .DIV_CYC(10)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .d_md(d_md), .md_start(md_start), .md_div(md_div), .flush(flush),
    .stall(stall), .rs_sel(rs_sel), .rt_sel(rt_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       rst;
    logic       dv;
    logic [4:0] rs;
    logic [2:0] urs;
    logic [4:0] rt;
    logic [2:0] urt;
    logic       wr;
    logic [4:0] wa;
    logic [2:0] tn;
    logic       md;
    logic       mds;
    logic       mdd;
    logic       fl;
    logic       est;
    logic [1:0] ers;
    logic [1:0] ert;
    logic       ebusy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string nm, int rst, int dv, int rs, int urs, int rt, int urt,
                              int wr, int wa, int tn, int md, int mds, int mdd, int fl,
                              int est, int ers, int ert, int ebusy);
    vec_t v;
    v.nm = nm;      v.rst = (rst != 0); v.dv = (dv != 0);
    v.rs = 5'(rs);  v.urs = 3'(urs);    v.rt = 5'(rt);     v.urt = 3'(urt);
    v.wr = (wr != 0); v.wa = 5'(wa);    v.tn = 3'(tn);
    v.md = (md != 0); v.mds = (mds != 0); v.mdd = (mdd != 0); v.fl = (fl != 0);
    v.est = (est != 0); v.ers = 2'(ers); v.ert = 2'(ert); v.ebusy = (ebusy != 0);
    return v;
  endfunction

  // Pipeline-only vector: MDU inputs idle, no reset, md_busy expected low.
  function automatic vec_t pv(string nm, int dv, int rs, int urs, int rt, int urt,
                              int wr, int wa, int tn, int fl, int est, int ers, int ert);
    return mk(nm, 0, dv, rs, urs, rt, urt, wr, wa, tn, 0, 0, 0, fl, est, ers, ert, 0);
  endfunction

  // MDU-only vector: no register sources or destination.
  function automatic vec_t mv(string nm, int dv, int md, int mds, int mdd, int est, int ebusy);
    return mk(nm, 0, dv, 0, U, 0, U, 0, 0, 0, md, mds, mdd, 0, est, 0, 0, ebusy);
  endfunction

  task automatic chk(string nm, string f, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h", nm, f, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset     = v.rst;  d_valid  = v.dv;
    d_rs      = v.rs;   d_tuse_rs = v.urs;
    d_rt      = v.rt;   d_tuse_rt = v.urt;
    d_wr_en   = v.wr;   d_wr_addr = v.wa;  d_tnew = v.tn;
    d_md      = v.md;   md_start  = v.mds; md_div = v.mdd;
    flush     = v.fl;
    sb.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      chk(e.nm, "stall",   8'(stall),   8'(e.est));
      chk(e.nm, "rs_sel",  8'(rs_sel),  8'(e.ers));
      chk(e.nm, "rt_sel",  8'(rt_sel),  8'(e.ert));
      chk(e.nm, "md_busy", 8'(md_busy), 8'(e.ebusy));
    end
  endtask

  task automatic step(vec_t v);
    drive(v);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; d_valid = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = '1; d_tuse_rt = '1;
    d_wr_en = 1'b0; d_wr_addr = '0; d_tnew = '0; d_md = 1'b0; md_start = 1'b0;
    md_div = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    //                name          dv rs urs rt urt wr wa tn fl  st rs rt
    tbl.push_back(pv("reset_state", 0, 0, U,  0, U,  0, 0, 0, 0,  0, 0, 0));
    // load-use: lw $8 then add using $8
    tbl.push_back(pv("lw8_issue",   1, 0, U,  0, U,  1, 8, 2, 0,  0, 0, 0));
    tbl.push_back(pv("lu_stall",    1, 8, 1,  0, U,  1, 10,1, 0,  1, 1, 0));
    tbl.push_back(pv("lu_fwd",      1, 8, 1,  0, U,  1, 10,1, 0,  0, 2, 0));
    tbl.push_back(pv("drain_flush", 0, 0, U,  0, U,  0, 0, 0, 1,  0, 0, 0));
    // ALU chain, then beq needing the value one cycle earlier
    tbl.push_back(pv("addu9",       1, 0, U,  0, U,  1, 9, 1, 0,  0, 0, 0));
    tbl.push_back(pv("alu_fwd",     1, 9, 1,  0, U,  1, 11,1, 0,  0, 1, 0));
    tbl.push_back(pv("addu9_again", 1, 0, U,  0, U,  1, 9, 1, 0,  0, 0, 0));
    tbl.push_back(pv("beq_stall",   1, 9, 0,  11,0,  0, 0, 0, 0,  1, 1, 2));
    tbl.push_back(pv("beq_fwd",     1, 9, 0,  11,0,  0, 0, 0, 0,  0, 2, 3));
    // register 0 never matches
    tbl.push_back(pv("r0_prod",     1, 0, U,  0, U,  1, 0, 2, 0,  0, 0, 0));
    tbl.push_back(pv("r0_use",      1, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0));
    // flush beats a simultaneous issue of another lw $8
    tbl.push_back(pv("lw8_pre",     1, 0, U,  0, U,  1, 8, 2, 0,  0, 0, 0));
    tbl.push_back(pv("flush_issue", 1, 0, U,  0, U,  1, 8, 2, 1,  0, 0, 0));
    tbl.push_back(pv("post_flush",  1, 8, 0,  8, 0,  0, 0, 0, 0,  0, 0, 0));
    // two producers of $12: youngest (ready) wins over older (not ready)
    tbl.push_back(pv("y_old",       1, 0, U,  0, U,  1, 12,3, 0,  0, 0, 0));
    tbl.push_back(pv("y_new",       1, 0, U,  0, U,  1, 12,0, 0,  0, 0, 0));
    tbl.push_back(pv("y_use",       1, 12,0,  12,0,  0, 0, 0, 0,  0, 1, 1));
    tbl.push_back(pv("final_flush", 0, 0, U,  0, U,  0, 0, 0, 1,  0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    // div started in E with mflo waiting in D: start cycle plus ten busy cycles
    step(mv("md_start", 1, 1, 1, 1, MDU, 0));
    for (int i = 1; i <= 10; i++) step(mv("md_wait", 1, 1, 0, 0, MDU, MDU));
    step(mv("md_done", 1, 1, 0, 0, 0, 0));

    // a mult started while the div is busy reloads the counter with 5
    step(mv("rl_start", 0, 0, 1, 1, 0, 0));
    for (int i = 1; i <= 8; i++) step(mv("rl_busy", 0, 0, (i == 3) ? 1 : 0, 0, 0, MDU));
    step(mv("rl_idle", 0, 0, 0, 0, 0, 0));

    // reset while producers are in flight and the counter sits at 7
    step(mk("ro_issue", 0, 1, 0, U, 0, U, 1, 8, 2, 0, 1, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 3; i++) step(pvb(i));
    step(mk("ro_reset", 1, 0, 0, U, 0, U, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MDU));
    step(mk("ro_after", 0, 1, 9, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Issue $9 producers while the div counts down (10, 9, 8 visible in these cycles).
  function automatic vec_t pvb(int i);
    vec_t v;
    v = pv("ro_fill", 1, 0, U, 0, U, 1, 9, 3, 0, 0, 0, 0);
    v.ebusy = (MDU != 0) && (i >= 1);
    return v;
  endfunction

endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of in-flight tracked stages after D (1=E, 2=M, 3=W).
REQ-002 SHALL have parameter AW, default 5, meaning the register address width.
REQ-003 SHALL have parameter TW, default 3, meaning the width of the Tuse/Tnew fields.
REQ-004 SHALL have parameter MULT_CYC, default 5, meaning the mult busy cycles.
REQ-005 SHALL have parameter DIV_CYC, default 10, meaning the div busy cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port d_valid, input, 1 bit: the D-stage instruction is valid.
REQ-009 SHALL have ports d_rs and d_rt, input, AW bits each: the D-stage source registers.
REQ-010 SHALL have ports d_tuse_rs and d_tuse_rt, input, TW bits each: cycles until the operand is needed; all-ones means unused.
REQ-011 SHALL have ports d_wr_en (1 bit), d_wr_addr (AW bits) and d_tnew (TW bits), all inputs: the destination write enable, address, and cycles until the result is forwardable, measured from E entry.
REQ-012 SHALL have port d_md, input, 1 bit: the D instruction uses HI/LO or the MDU.
REQ-013 SHALL have ports md_start (1 bit) and md_div (1 bit), both inputs: a mult/div starts in E this cycle; md_div=1 selects div.
REQ-014 SHALL have port flush, input, 1 bit: kill all tracked in-flight entries.
REQ-015 SHALL have port stall, output, 1 bit: freeze F/D and insert a bubble into E.
REQ-016 SHALL have ports rs_sel and rt_sel, output, $clog2(DEPTH+1) bits each: forwarding source; 0 = register file, k = stage k.
REQ-017 SHALL have port md_busy, output, 1 bit: the MDU busy counter is nonzero.

Function
REQ-018 SHALL hold a shift register of DEPTH entries {valid, wr, addr, tnew}, where entry 1 is E.
REQ-019 SHALL, each cycle, move entry k to k+1, drop the entry leaving stage DEPTH, and decrement tnew saturating at 0.
REQ-020 SHALL load entry 1 with {1, d_wr_en, d_wr_addr, d_tnew} when d_valid & ~stall, and otherwise with valid=0 (bubble).
REQ-021 SHALL treat entry k as matching a source when valid & wr & addr==src & src!=0.
REQ-022 SHALL define the hazard for a source as: the youngest matching entry has tnew > that source's tuse.
REQ-023 SHALL assert stall = d_valid & (hazard on rs | hazard on rt | md hazard), combinationally from registered state and D inputs.
REQ-024 SHALL drive rs_sel/rt_sel with the index of the youngest matching entry, or 0 if there is none or the source is register 0.
REQ-025 SHALL use a busy counter that loads MULT_CYC or DIV_CYC on md_start and decrements to 0 otherwise.
REQ-026 SHALL assert md_busy when the counter is nonzero.
REQ-027 SHALL raise an md hazard when d_md & (md_busy | md_start).
REQ-028 SHALL, on flush, clear all entry valid bits next cycle; flush takes priority over a simultaneous issue, so no entry loads.
REQ-029 SHALL leave the MDU counter unaffected by flush.
REQ-030 SHALL let a second md_start while busy reload the counter.
REQ-031 SHALL ensure that a stalled instruction sees, next cycle, its blocking producer one stage older with tnew reduced by 1.

Reset
REQ-032 SHALL, while reset is high at a clock edge, clear all entries to valid=0, tnew=0, and the MDU counter to 0.
REQ-033 SHALL, after reset, hold stall=0, rs_sel=0, rt_sel=0 and md_busy=0 until new state is loaded.
REQ-034 SHALL give reset priority over flush, issue and md_start.
REQ-035 SHALL discard all in-flight tracking and MDU countdown when reset is asserted mid-operation.

Configuration
REQ-036 SHALL compile the MDU tracking when macro HAZARD_SB_MDU_EN is defined.
REQ-037 SHALL, without HAZARD_SB_MDU_EN, omit the counter, hold md_busy at 0, exclude the md hazard from stall, and ignore d_md/md_start/md_div.

Verification
REQ-038 SHALL verify load-use: lw $8 (d_tnew=2) issued, then add using $8 (tuse_rs=1) -> stall=1 for 1 cycle, then rs_sel=2, stall=0.
REQ-039 SHALL verify ALU chain: addu $9 (tnew=1), then addu using $9 with tuse=1 -> stall=0, rs_sel=1; with tuse=0 (beq) -> stall=1 for 1 cycle, then rs_sel=2.
REQ-040 SHALL verify register 0: producer wr_addr=0, consumer d_rs=0 -> stall=0, rs_sel=0.
REQ-041 SHALL verify flush: lw $8 in E, flush=1 together with d_valid -> next cycle a consumer of $8 sees stall=0, rs_sel=0.
REQ-042 SHALL verify MDU: md_start, md_div=1, then mflo with d_md=1 -> stall=1 for 11 cycles (10 busy plus the start cycle), md_busy falls after 10 cycles.
REQ-043 SHALL verify reset mid-operation: reset with entries valid and the counter at 7 -> next cycle stall=0, sels=0, md_busy=0.
